reorder_buffer: RTL and testbench

Sixteen-entry circular reorder buffer at the far end of the dispatch interface. It allocates a tag to each instruction dispatched, and it collects results from two completion ports. Completed results are rebroadcast to the reservation stations. Retirement is in order, up to two per cycle, into the register file's write ports (WE/WA/WD/WT). A mispredicted branch reaching the head triggers a pipeline flush.

---
 rtl/reorder_buffer_pkg.sv | 35 +++
 rtl/reorder_buffer_skid.sv | 49 ++++
 rtl/reorder_buffer.sv | 168 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: geometry, entry record, commit-slot
// record (also consumed by the register file) and the completion-bus record.
package reorder_buffer_pkg;

   localparam int ROB_TAGW  = 4;
   localparam int ROB_DEPTH = 2 ** ROB_TAGW;

   // One reorder-buffer slot.
   typedef struct packed {
      logic        valid;
      logic        done;
      logic [4:0]  dst;
      logic        regwrite;
      logic        isstore;
      logic        isbranch;
      logic        mispred;
      logic [31:0] result;
   } rob_entry_t;

   // One register-file write port worth of retirement information.
   typedef struct packed {
      logic                we;
      logic [4:0]          wa;
      logic [31:0]         wd;
      logic [ROB_TAGW-1:0] wt;
   } commit_slot_t;

   // A completion / broadcast beat.
   typedef struct packed {
      logic                valid;
      logic [ROB_TAGW-1:0] tag;
      logic [31:0]         result;
   } cdb_t;

endpackage

// File: rtl/reorder_buffer_skid.sv
// Broadcast stage: picks one completion per cycle for the reservation
// stations. A losing port-2 completion waits in a one-entry skid and wins
// the following cycle.
module reorder_buffer_skid
   import reorder_buffer_pkg::*;
(
   input  logic clk_i,
   input  logic reset_i,
   input  logic flush_i,
   input  cdb_t p1_i,
   input  cdb_t p2_i,
   output cdb_t bcast_o,
   output logic ready2_o
);

   cdb_t skid_q, skid_d;
   cdb_t bcast_q, bcast_d;

   // Arbitration: skid first, then port 1, then port 2. Whatever loses
   // while the skid drains takes the skid's place, so nothing is dropped.
   always_comb begin
      skid_d  = '0;
      bcast_d = '0;
      if (skid_q.valid) begin
         bcast_d = skid_q;
         skid_d  = p1_i;      // port 2 is held off while the skid is full
      end else if (p1_i.valid) begin
         bcast_d = p1_i;
         skid_d  = p2_i;
      end else begin
         bcast_d = p2_i;
      end
   end

   // Register the broadcast and the skid; a flush discards both.
   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) begin
         skid_q  <= '0;
         bcast_q <= '0;
      end else begin
         skid_q  <= skid_d;
         bcast_q <= bcast_d;
      end
   end

   assign bcast_o  = bcast_q;
   assign ready2_o = !skid_q.valid;

endmodule

// File: rtl/reorder_buffer.sv
// Sixteen-entry circular reorder buffer: tag allocation at dispatch, two
// completion ports with a registered broadcast, in-order dual retirement
// into the register file and a flush when a mispredicted branch retires.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int TAGW  = ROB_TAGW
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            AllocReq,
   input  logic [4:0]      AllocDst,
   input  logic            AllocRegWrite,
   input  logic            AllocIsStore,
   input  logic            AllocIsBranch,
   output logic [TAGW-1:0] ROBRFTag,
   output logic [4:0]      ROBRFDst,
   output logic            ROBRFE,
   output logic            ROBstall,
   input  logic            CDBValid1,
   input  logic            CDBValid2,
   input  logic [TAGW-1:0] CDBTag1,
   input  logic [TAGW-1:0] CDBTag2,
   input  logic [31:0]     CDBResult1,
   input  logic [31:0]     CDBResult2,
   input  logic            CDBMispred1,
   input  logic            CDBMispred2,
   output logic            CDBReady2,
   output logic [TAGW-1:0] ROBRSTag,
   output logic [31:0]     ROBRSResult,
   output logic            ROBRSModify,
   output logic            WE1,
   output logic            WE2,
   output logic [4:0]      WA1,
   output logic [4:0]      WA2,
   output logic [31:0]     WD1,
   output logic [31:0]     WD2,
   output logic [TAGW-1:0] WT1,
   output logic [TAGW-1:0] WT2,
   output logic            StoreCommit,
   output logic [TAGW-1:0] ROBhead,
   output logic            ROBFlush,
   output logic [31:0]     FlushPC
);

   rob_entry_t      ent_q [DEPTH];
   logic [TAGW-1:0] head_q, tail_q, head1;
   logic [TAGW:0]   count_q, count_d;
   commit_slot_t    slot1_q, slot2_q, slot1_d, slot2_d;
   logic            store_q, flush_q;
   logic [31:0]     flushpc_q;

   rob_entry_t e0, e1;
   logic       alloc, ret1, ret2, flush_now, ready2;
   cdb_t       p1, p2, bcast;

   // Retire selection, allocation acceptance and next count.
   always_comb begin
      head1     = head_q + TAGW'(1);
      e0        = ent_q[head_q];
      e1        = ent_q[head1];
      ROBstall  = (count_q == (TAGW+1)'(DEPTH)) | flush_q;
      alloc     = AllocReq & !ROBstall;
      ret1      = e0.valid & e0.done;
      // Slot 2 never takes a store, never follows a store or a mispredicted
      // head, and never takes a mispredicted branch itself: only slot 1 can
      // raise the flush.
      ret2      = ret1 & e1.valid & e1.done & !e0.mispred & !e0.isstore
                  & !e1.isstore & !e1.mispred;
      flush_now = ret1 & e0.isbranch & e0.mispred;
      count_d   = count_q + (TAGW+1)'(alloc) - (TAGW+1)'(ret1) - (TAGW+1)'(ret2);
      slot1_d   = '0;
      slot2_d   = '0;
      if (ret1) slot1_d = '{we: e0.regwrite, wa: e0.dst, wd: e0.result, wt: ROB_TAGW'(head_q)};
      if (ret2) slot2_d = '{we: e1.regwrite, wa: e1.dst, wd: e1.result, wt: ROB_TAGW'(head1)};
   end

   // Completions only count against live entries and are dropped while
   // the flush pulse is out; port 2 is honoured only when the skid is free.
   always_comb begin
      p1.valid  = CDBValid1 & ent_q[CDBTag1].valid & !flush_q;
      p1.tag    = ROB_TAGW'(CDBTag1);
      p1.result = CDBResult1;
      p2.valid  = CDBValid2 & ready2 & ent_q[CDBTag2].valid & !flush_q;
      p2.tag    = ROB_TAGW'(CDBTag2);
      p2.result = CDBResult2;
   end

   reorder_buffer_skid u_skid (
      .clk_i    (CLK),
      .reset_i  (reset),
      .flush_i  (flush_now),
      .p1_i     (p1),
      .p2_i     (p2),
      .bcast_o  (bcast),
      .ready2_o (ready2)
   );

   // Entry array, pointers and registered commit/flush outputs.
   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         slot1_q   <= '0;
         slot2_q   <= '0;
         store_q   <= 1'b0;
         flush_q   <= 1'b0;
         flushpc_q <= '0;
      end else begin
         if (p1.valid) begin
            ent_q[CDBTag1].done    <= 1'b1;
            ent_q[CDBTag1].result  <= CDBResult1;
            ent_q[CDBTag1].mispred <= CDBMispred1;
         end
         if (p2.valid) begin
            ent_q[CDBTag2].done    <= 1'b1;
            ent_q[CDBTag2].result  <= CDBResult2;
            ent_q[CDBTag2].mispred <= CDBMispred2;
         end
         if (ret1) ent_q[head_q].valid <= 1'b0;
         if (ret2) ent_q[head1].valid  <= 1'b0;
         if (alloc)
            ent_q[tail_q] <= '{valid: 1'b1, done: 1'b0, dst: AllocDst,
                               regwrite: AllocRegWrite, isstore: AllocIsStore,
                               isbranch: AllocIsBranch, mispred: 1'b0, result: '0};
         head_q  <= head_q + TAGW'(ret1) + TAGW'(ret2);
         tail_q  <= tail_q + TAGW'(alloc);
         count_q <= count_d;
         // Wrong-path work is discarded wholesale; this overrides the
         // updates above, including a same-cycle allocation.
         if (flush_now) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end
         slot1_q   <= slot1_d;
         slot2_q   <= slot2_d;
         store_q   <= ret1 & e0.isstore;
         flush_q   <= flush_now;
         flushpc_q <= flush_now ? e0.result : '0;
      end
   end

   assign ROBRFTag    = tail_q;
   assign ROBRFDst    = AllocDst;
   assign ROBRFE      = AllocReq & AllocRegWrite & !ROBstall;
   assign CDBReady2   = ready2;
   assign ROBRSTag    = TAGW'(bcast.tag);
   assign ROBRSResult = bcast.result;
   assign ROBRSModify = bcast.valid;
   assign WE1         = slot1_q.we;
   assign WA1         = slot1_q.wa;
   assign WD1         = slot1_q.wd;
   assign WT1         = TAGW'(slot1_q.wt);
   assign WE2         = slot2_q.we;
   assign WA2         = slot2_q.wa;
   assign WD2         = slot2_q.wd;
   assign WT2         = TAGW'(slot2_q.wt);
   assign StoreCommit = store_q;
   assign ROBhead     = head_q;
   assign ROBFlush    = flush_q;
   assign FlushPC     = flushpc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation/stall, dual completion and
// skid, store retirement, mispredict flush, wrap-around, bad tags, reset.
module tb_reorder_buffer;

   logic        CLK, reset;
   logic        AllocReq, AllocRegWrite, AllocIsStore, AllocIsBranch;
   logic [4:0]  AllocDst;
   logic [3:0]  ROBRFTag;
   logic [4:0]  ROBRFDst;
   logic        ROBRFE, ROBstall;
   logic        CDBValid1, CDBValid2, CDBMispred1, CDBMispred2, CDBReady2;
   logic [3:0]  CDBTag1, CDBTag2;
   logic [31:0] CDBResult1, CDBResult2;
   logic [3:0]  ROBRSTag;
   logic [31:0] ROBRSResult;
   logic        ROBRSModify;
   logic        WE1, WE2;
   logic [4:0]  WA1, WA2;
   logic [31:0] WD1, WD2;
   logic [3:0]  WT1, WT2;
   logic        StoreCommit;
   logic [3:0]  ROBhead;
   logic        ROBFlush;
   logic [31:0] FlushPC;

   int ncmp = 0;
   int nerr = 0;

   reorder_buffer #(.DEPTH(16), .TAGW(4)) dut (
      .CLK(CLK), .reset(reset),
      .AllocReq(AllocReq), .AllocDst(AllocDst), .AllocRegWrite(AllocRegWrite),
      .AllocIsStore(AllocIsStore), .AllocIsBranch(AllocIsBranch),
      .ROBRFTag(ROBRFTag), .ROBRFDst(ROBRFDst), .ROBRFE(ROBRFE), .ROBstall(ROBstall),
      .CDBValid1(CDBValid1), .CDBValid2(CDBValid2), .CDBTag1(CDBTag1), .CDBTag2(CDBTag2),
      .CDBResult1(CDBResult1), .CDBResult2(CDBResult2),
      .CDBMispred1(CDBMispred1), .CDBMispred2(CDBMispred2), .CDBReady2(CDBReady2),
      .ROBRSTag(ROBRSTag), .ROBRSResult(ROBRSResult), .ROBRSModify(ROBRSModify),
      .WE1(WE1), .WE2(WE2), .WA1(WA1), .WA2(WA2), .WD1(WD1), .WD2(WD2),
      .WT1(WT1), .WT2(WT2), .StoreCommit(StoreCommit), .ROBhead(ROBhead),
      .ROBFlush(ROBFlush), .FlushPC(FlushPC)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are read there too.
   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic idle();
      AllocReq = 1'b0; AllocDst = 5'd0; AllocRegWrite = 1'b0;
      AllocIsStore = 1'b0; AllocIsBranch = 1'b0;
      CDBValid1 = 1'b0; CDBTag1 = 4'd0; CDBResult1 = 32'd0; CDBMispred1 = 1'b0;
      CDBValid2 = 1'b0; CDBTag2 = 4'd0; CDBResult2 = 32'd0; CDBMispred2 = 1'b0;
   endtask

   task automatic alloc(input logic [4:0] dst, input logic rw, input logic st, input logic br);
      AllocReq = 1'b1; AllocDst = dst; AllocRegWrite = rw;
      AllocIsStore = st; AllocIsBranch = br;
   endtask

   task automatic cdb1(input logic [3:0] tag, input logic [31:0] res, input logic mp);
      CDBValid1 = 1'b1; CDBTag1 = tag; CDBResult1 = res; CDBMispred1 = mp;
   endtask

   task automatic cdb2(input logic [3:0] tag, input logic [31:0] res, input logic mp);
      CDBValid2 = 1'b1; CDBTag2 = tag; CDBResult2 = res; CDBMispred2 = mp;
   endtask

   initial begin
      // Reset state
      reset = 1'b1; idle(); tick(); tick();
      chk("rst_tag",   32'(ROBRFTag), 0);
      chk("rst_stall", 32'(ROBstall), 0);
      chk("rst_we1",   32'(WE1), 0);
      chk("rst_mod",   32'(ROBRSModify), 0);
      chk("rst_flush", 32'(ROBFlush), 0);
      chk("rst_head",  32'(ROBhead), 0);
      reset = 1'b0;

      // Sixteen back-to-back allocations, then full
      for (int i = 0; i < 16; i++) begin
         alloc(5'(i), 1'b1, 1'b0, 1'b0); #1;
         chk("t1_tag", 32'(ROBRFTag), 32'(i));
         chk("t1_rfe", 32'(ROBRFE), 1);
         tick();
      end
      alloc(5'd20, 1'b1, 1'b0, 1'b0); #1;
      chk("t1_stall",    32'(ROBstall), 1);
      chk("t1_rfe_full", 32'(ROBRFE), 0);
      chk("t1_dst",      32'(ROBRFDst), 20);
      tick(); idle(); #1;
      chk("t1_tail",       32'(ROBRFTag), 0);
      chk("t1_stall_hold", 32'(ROBstall), 1);

      // Dual completion, skid, paired commit
      reset = 1'b1; tick(); reset = 1'b0;
      alloc(5'd3, 1'b1, 1'b0, 1'b0); tick();
      alloc(5'd4, 1'b1, 1'b0, 1'b0); tick(); idle();
      cdb1(4'd0, 32'hA, 1'b0); cdb2(4'd1, 32'hB, 1'b0); #1;
      chk("t2_rdy_pre", 32'(CDBReady2), 1);
      tick(); idle();
      chk("t2_bc0_mod", 32'(ROBRSModify), 1);
      chk("t2_bc0_tag", 32'(ROBRSTag), 0);
      chk("t2_bc0_res", ROBRSResult, 32'hA);
      chk("t2_rdy_low", 32'(CDBReady2), 0);
      chk("t2_no_early_commit", 32'(WE1), 0);
      tick();
      chk("t2_bc1_mod", 32'(ROBRSModify), 1);
      chk("t2_bc1_tag", 32'(ROBRSTag), 1);
      chk("t2_bc1_res", ROBRSResult, 32'hB);
      chk("t2_rdy_back", 32'(CDBReady2), 1);
      chk("t2_we1", 32'(WE1), 1);
      chk("t2_wa1", 32'(WA1), 3);
      chk("t2_wd1", WD1, 32'hA);
      chk("t2_wt1", 32'(WT1), 0);
      chk("t2_we2", 32'(WE2), 1);
      chk("t2_wa2", 32'(WA2), 4);
      chk("t2_wd2", WD2, 32'hB);
      chk("t2_wt2", 32'(WT2), 1);
      chk("t2_head", 32'(ROBhead), 2);
      tick();
      chk("t2_mod_off", 32'(ROBRSModify), 0);
      chk("t2_we1_off", 32'(WE1), 0);

      // Store at head retires alone
      alloc(5'd0, 1'b0, 1'b1, 1'b0); tick();
      alloc(5'd7, 1'b1, 1'b0, 1'b0); tick(); idle();
      cdb1(4'd2, 32'h100, 1'b0); cdb2(4'd3, 32'h33, 1'b0); tick(); idle();
      tick();
      chk("t3_sc",    32'(StoreCommit), 1);
      chk("t3_we1_s", 32'(WE1), 0);
      chk("t3_wt1_s", 32'(WT1), 2);
      chk("t3_we2_s", 32'(WE2), 0);
      chk("t3_head_s", 32'(ROBhead), 3);
      tick();
      chk("t3_sc_off", 32'(StoreCommit), 0);
      chk("t3_we1",  32'(WE1), 1);
      chk("t3_wa1",  32'(WA1), 7);
      chk("t3_wd1",  WD1, 32'h33);
      chk("t3_wt1",  32'(WT1), 3);
      chk("t3_we2",  32'(WE2), 0);
      chk("t3_head", 32'(ROBhead), 4);

      // Mispredicted branch at tag 2 flushes younger tags 3..5
      reset = 1'b1; tick(); reset = 1'b0;
      alloc(5'd1,  1'b1, 1'b0, 1'b0); tick();
      alloc(5'd2,  1'b1, 1'b0, 1'b0); tick();
      alloc(5'd0,  1'b0, 1'b0, 1'b1); tick();
      alloc(5'd10, 1'b1, 1'b0, 1'b0); tick();
      alloc(5'd11, 1'b1, 1'b0, 1'b0); tick();
      alloc(5'd12, 1'b1, 1'b0, 1'b0); tick(); idle();
      cdb1(4'd3, 32'h3, 1'b0); cdb2(4'd4, 32'h4, 1'b0); tick(); idle();
      cdb1(4'd5, 32'h5, 1'b0); tick(); idle();
      cdb1(4'd0, 32'h10, 1'b0); tick(); idle();
      cdb1(4'd1, 32'h20, 1'b0); tick(); idle();
      chk("t4_we1_t0", 32'(WE1), 1);
      chk("t4_wa1_t0", 32'(WA1), 1);
      chk("t4_wd1_t0", WD1, 32'h10);
      chk("t4_we2_t0", 32'(WE2), 0);
      cdb1(4'd2, 32'h40, 1'b1); tick(); idle();
      chk("t4_we1_t1", 32'(WE1), 1);
      chk("t4_wa1_t1", 32'(WA1), 2);
      chk("t4_wd1_t1", WD1, 32'h20);
      chk("t4_we2_t1", 32'(WE2), 0);
      tick();
      chk("t4_flush",  32'(ROBFlush), 1);
      chk("t4_fpc",    FlushPC, 32'h40);
      chk("t4_stall",  32'(ROBstall), 1);
      chk("t4_wt1_br", 32'(WT1), 2);
      chk("t4_we1_br", 32'(WE1), 0);
      chk("t4_we2_br", 32'(WE2), 0);
      chk("t4_head",   32'(ROBhead), 0);
      chk("t4_tail",   32'(ROBRFTag), 0);
      alloc(5'd9, 1'b1, 1'b0, 1'b0); cdb1(4'd3, 32'h77, 1'b0); #1;
      chk("t4_rfe_flush", 32'(ROBRFE), 0);
      tick(); idle();
      chk("t4_flush_off", 32'(ROBFlush), 0);
      chk("t4_stall_off", 32'(ROBstall), 0);
      chk("t4_tail_kept", 32'(ROBRFTag), 0);
      chk("t4_drop_bc",   32'(ROBRSModify), 0);
      chk("t4_we1_after", 32'(WE1), 0);
      chk("t4_we2_after", 32'(WE2), 0);
      tick(); tick();
      chk("t4_we1_late", 32'(WE1), 0);
      chk("t4_we2_late", 32'(WE2), 0);

      // Wrap-around: bring head to 14, commit pair (14, 15)
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 14; i++) begin
         alloc(5'd0, 1'b0, 1'b0, 1'b0); tick();
      end
      idle();
      for (int i = 0; i < 14; i++) begin
         cdb1(4'(i), 32'(i), 1'b0); tick();
      end
      idle(); tick(); tick(); tick();
      chk("t5_head14", 32'(ROBhead), 14);
      alloc(5'd5, 1'b1, 1'b0, 1'b0); #1;
      chk("t5_tag14", 32'(ROBRFTag), 14);
      tick();
      alloc(5'd6, 1'b1, 1'b0, 1'b0); #1;
      chk("t5_tag15", 32'(ROBRFTag), 15);
      tick();
      alloc(5'd8, 1'b1, 1'b0, 1'b0); #1;
      chk("t5_tag0", 32'(ROBRFTag), 0);
      tick(); idle();
      cdb1(4'd14, 32'hE, 1'b0); cdb2(4'd15, 32'hF, 1'b0); tick(); idle();
      tick();
      chk("t5_we1", 32'(WE1), 1);
      chk("t5_wa1", 32'(WA1), 5);
      chk("t5_wd1", WD1, 32'hE);
      chk("t5_wt1", 32'(WT1), 14);
      chk("t5_we2", 32'(WE2), 1);
      chk("t5_wa2", 32'(WA2), 6);
      chk("t5_wd2", WD2, 32'hF);
      chk("t5_wt2", 32'(WT2), 15);
      chk("t5_head0", 32'(ROBhead), 0);

      // Completion to an unallocated tag
      cdb1(4'd5, 32'h99, 1'b0); tick(); idle();
      chk("t6_bad_bc", 32'(ROBRSModify), 0);
      chk("t6_rdy",    32'(CDBReady2), 1);
      tick();
      chk("t6_bad_we",   32'(WE1), 0);
      chk("t6_bad_head", 32'(ROBhead), 0);
      chk("t6_bad_tail", 32'(ROBRFTag), 1);

      // Reset mid-stream, just before tag 0 would commit
      cdb1(4'd0, 32'h55, 1'b0); tick(); idle();
      chk("t6_bc_mod", 32'(ROBRSModify), 1);
      chk("t6_bc_tag", 32'(ROBRSTag), 0);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("t6_rst_we1",   32'(WE1), 0);
      chk("t6_rst_wa1",   32'(WA1), 0);
      chk("t6_rst_wd1",   WD1, 0);
      chk("t6_rst_mod",   32'(ROBRSModify), 0);
      chk("t6_rst_head",  32'(ROBhead), 0);
      chk("t6_rst_tag",   32'(ROBRFTag), 0);
      chk("t6_rst_sc",    32'(StoreCommit), 0);
      chk("t6_rst_flush", 32'(ROBFlush), 0);
      chk("t6_rst_stall", 32'(ROBstall), 0);
      tick();
      chk("t6_rst_we1_late", 32'(WE1), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
